// File: rtl/sa48_slice_sender_if.sv
// rtl/sa48_slice_sender_if.sv - operand, slice-datapath and result signal bundle for sa48_slice_sender
//
// Purpose: groups every handshake and bus signal of the slice sender so the
//   sender and its environment connect through one port.
// Optional feature: SA48_OVF_EN adds res_ovf (signed overflow of the result).
// Signals:
//   op_valid/op_ready       operand pair handshake (upstream -> sender)
//   op_a, op_b, op_ci       48-bit operands and carry-in
//   bus_a, bus_b            12-bit operand slice to the datapath
//   flag1..flag4            one-hot slice strobes
//   load_ready              concatenate strobe to the datapath
//   ci48                    datapath carry-in
//   dp_result, dp_co        datapath sum and carry-out
//   res_valid/res_ready     result handshake (sender -> downstream)
//   res_sum, res_co         captured result
//   res_ovf                 captured signed overflow (SA48_OVF_EN only)
// Modports: slave = the sender itself, master = its environment.

interface sa48_slice_sender_if;
  logic        op_valid;
  logic        op_ready;
  logic [47:0] op_a;
  logic [47:0] op_b;
  logic        op_ci;

  logic [11:0] bus_a;
  logic [11:0] bus_b;
  logic        flag1;
  logic        flag2;
  logic        flag3;
  logic        flag4;
  logic        load_ready;
  logic        ci48;

  logic [47:0] dp_result;
  logic        dp_co;

  logic        res_valid;
  logic        res_ready;
  logic [47:0] res_sum;
  logic        res_co;
`ifdef SA48_OVF_EN
  logic        res_ovf;
`endif

  modport slave (
    input  op_valid,
    output op_ready,
    input  op_a,
    input  op_b,
    input  op_ci,
    output bus_a,
    output bus_b,
    output flag1,
    output flag2,
    output flag3,
    output flag4,
    output load_ready,
    output ci48,
    input  dp_result,
    input  dp_co,
    output res_valid,
    input  res_ready,
    output res_sum,
    output res_co
`ifdef SA48_OVF_EN
    ,
    output res_ovf
`endif
  );

  modport master (
    output op_valid,
    input  op_ready,
    output op_a,
    output op_b,
    output op_ci,
    input  bus_a,
    input  bus_b,
    input  flag1,
    input  flag2,
    input  flag3,
    input  flag4,
    input  load_ready,
    input  ci48,
    output dp_result,
    output dp_co,
    input  res_valid,
    output res_ready,
    input  res_sum,
    input  res_co
`ifdef SA48_OVF_EN
    ,
    input  res_ovf
`endif
  );
endinterface

// File: rtl/sa48_slice_sender.sv
// rtl/sa48_slice_sender.sv - feeds 48-bit operands to a 12-bit-sliced adder datapath and returns its result
//
// Purpose: accepts one operand pair, presents it to the datapath as four
//   12-bit slices (least significant first) with one-hot strobes, pulses
//   load_ready to concatenate, captures the 48-bit sum and carry-out, offers
//   it on a valid/ready handshake, then idles GAP cycles before accepting again.
// Optional feature: macro SA48_OVF_EN adds res_ovf, the signed 48-bit overflow
//   of the captured result.
// Parameters:
//   GAP   idle cycles after each result handshake (0..15)
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   sif   sa48_slice_sender_if.slave (operand, slice bus, datapath, result)
// Timing: accept edge -> SL1, SL2, SL3, SL4, LOAD -> DONE (res_valid) in the
//   sixth cycle; issue interval is 7 + GAP cycles.

module sa48_slice_sender #(
  parameter int unsigned GAP = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  sa48_slice_sender_if.slave    sif
);

  localparam logic [3:0] GAP_CNT = 4'(GAP);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SL1  = 3'd1,
    SL2  = 3'd2,
    SL3  = 3'd3,
    SL4  = 3'd4,
    LOAD = 3'd5,
    DONE = 3'd6,
    GAPW = 3'd7
  } state_t;

  state_t      state;
  logic [3:0]  gap_cnt;

  // operands are sampled only on the accept edge
  logic [47:0] lat_a;
  logic [47:0] lat_b;

  logic        op_ready_q;
  logic [11:0] bus_a_q;
  logic [11:0] bus_b_q;
  logic [3:0]  flags_q;
  logic        load_ready_q;
  logic        ci48_q;
  logic        res_valid_q;
  logic [47:0] res_sum_q;
  logic        res_co_q;
`ifdef SA48_OVF_EN
  logic        res_ovf_q;
`endif

  // Every datapath-side output is assigned on the edge that enters the state
  // it belongs to, so all of them are plain registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      gap_cnt      <= 4'd0;
      lat_a        <= 48'd0;
      lat_b        <= 48'd0;
      op_ready_q   <= 1'b1;
      bus_a_q      <= 12'd0;
      bus_b_q      <= 12'd0;
      flags_q      <= 4'd0;
      load_ready_q <= 1'b0;
      ci48_q       <= 1'b0;
      res_valid_q  <= 1'b0;
      res_sum_q    <= 48'd0;
      res_co_q     <= 1'b0;
`ifdef SA48_OVF_EN
      res_ovf_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (sif.op_valid && op_ready_q) begin
            lat_a      <= sif.op_a;
            lat_b      <= sif.op_b;
            op_ready_q <= 1'b0;
            bus_a_q    <= sif.op_a[11:0];
            bus_b_q    <= sif.op_b[11:0];
            flags_q    <= 4'b0001;
            ci48_q     <= sif.op_ci;
            state      <= SL1;
          end
        end

        SL1: begin
          bus_a_q <= lat_a[23:12];
          bus_b_q <= lat_b[23:12];
          flags_q <= 4'b0010;
          state   <= SL2;
        end

        SL2: begin
          bus_a_q <= lat_a[35:24];
          bus_b_q <= lat_b[35:24];
          flags_q <= 4'b0100;
          state   <= SL3;
        end

        SL3: begin
          bus_a_q <= lat_a[47:36];
          bus_b_q <= lat_b[47:36];
          flags_q <= 4'b1000;
          state   <= SL4;
        end

        SL4: begin
          // bus stays on slice 4 while the datapath concatenates
          flags_q      <= 4'd0;
          load_ready_q <= 1'b1;
          state        <= LOAD;
        end

        LOAD: begin
          load_ready_q <= 1'b0;
          ci48_q       <= 1'b0;
          res_sum_q    <= sif.dp_result;
          res_co_q     <= sif.dp_co;
`ifdef SA48_OVF_EN
          res_ovf_q    <= (lat_a[47] == lat_b[47]) && (sif.dp_result[47] != lat_a[47]);
`endif
          res_valid_q  <= 1'b1;
          state        <= DONE;
        end

        DONE: begin
          if (sif.res_ready) begin
            res_valid_q <= 1'b0;
            if (GAP_CNT == 4'd0) begin
              op_ready_q <= 1'b1;
              state      <= IDLE;
            end else begin
              gap_cnt <= GAP_CNT;
              state   <= GAPW;
            end
          end
        end

        GAPW: begin
          // GAPW lasts exactly GAP cycles: leave on the edge that takes 1 -> 0
          if (gap_cnt <= 4'd1) begin
            gap_cnt    <= 4'd0;
            op_ready_q <= 1'b1;
            state      <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end

        default: begin
          state        <= IDLE;
          gap_cnt      <= 4'd0;
          op_ready_q   <= 1'b1;
          flags_q      <= 4'd0;
          load_ready_q <= 1'b0;
          ci48_q       <= 1'b0;
          res_valid_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sif.op_ready   = op_ready_q;
  assign sif.bus_a      = bus_a_q;
  assign sif.bus_b      = bus_b_q;
  assign sif.flag1      = flags_q[0];
  assign sif.flag2      = flags_q[1];
  assign sif.flag3      = flags_q[2];
  assign sif.flag4      = flags_q[3];
  assign sif.load_ready = load_ready_q;
  assign sif.ci48       = ci48_q;
  assign sif.res_valid  = res_valid_q;
  assign sif.res_sum    = res_sum_q;
  assign sif.res_co     = res_co_q;
`ifdef SA48_OVF_EN
  assign sif.res_ovf    = res_ovf_q;
`endif

endmodule

// File: tb/tb_sa48_slice_sender.sv
// tb/tb_sa48_slice_sender.sv - directed self-checking bench for sa48_slice_sender (GAP=1)

module tb_sa48_slice_sender;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  sa48_slice_sender_if sif ();

  sa48_slice_sender #(.GAP(1)) dut (
    .clk (clk),
    .rst (rst),
    .sif (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // datapath model: collects slices on their strobes, adds the full words
  logic [47:0] ma;
  logic [47:0] mb;
  always @(posedge clk) begin
    if (sif.flag1) begin ma[11:0]  <= sif.bus_a; mb[11:0]  <= sif.bus_b; end
    if (sif.flag2) begin ma[23:12] <= sif.bus_a; mb[23:12] <= sif.bus_b; end
    if (sif.flag3) begin ma[35:24] <= sif.bus_a; mb[35:24] <= sif.bus_b; end
    if (sif.flag4) begin ma[47:36] <= sif.bus_a; mb[47:36] <= sif.bus_b; end
  end
  assign {sif.dp_co, sif.dp_result} = {1'b0, ma} + {1'b0, mb} + {48'd0, sif.ci48};

  function automatic logic [4:0] strobes();
    return {sif.load_ready, sif.flag4, sif.flag3, sif.flag2, sif.flag1};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    sif.op_valid = 1'b0; sif.op_a = '0; sif.op_b = '0; sif.op_ci = 1'b0; sif.res_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (sif.op_ready !== 1'b1) begin errors++; $display("FAIL reset_op_ready: got %b expected 1", sif.op_ready); end
    checks++; if (sif.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b expected 0", sif.res_valid); end
    checks++; if (strobes() !== 5'b0) begin errors++; $display("FAIL reset_strobes: got %b expected 00000", strobes()); end
    checks++; if (sif.ci48 !== 1'b0) begin errors++; $display("FAIL reset_ci48: got %b expected 0", sif.ci48); end
    checks++; if ({sif.bus_a, sif.bus_b} !== 24'd0) begin errors++; $display("FAIL reset_bus: got %h/%h expected 0/0", sif.bus_a, sif.bus_b); end
    checks++; if ({sif.res_sum, sif.res_co} !== 49'd0) begin errors++; $display("FAIL reset_result: got %h/%b expected 0/0", sif.res_sum, sif.res_co); end
`ifdef SA48_OVF_EN
    checks++; if (sif.res_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", sif.res_ovf); end
`endif
    rst = 1'b0;
    @(negedge clk);
    checks++; if (sif.op_ready !== 1'b1) begin errors++; $display("FAIL post_reset_op_ready: got %b expected 1", sif.op_ready); end
  endtask

  // one operation from IDLE with full slice and latency checks, then handshake
  task automatic do_op(input logic [47:0] a, input logic [47:0] b, input logic ci,
                       input logic [47:0] esum, input logic eco, input logic eovf, input string nm);
    logic [47:0] ta;
    logic [47:0] tb2;
    logic [4:0]  est;
    int          s;
    sif.op_a = a; sif.op_b = b; sif.op_ci = ci; sif.op_valid = 1'b1; sif.res_ready = 1'b0;
    @(negedge clk);
    sif.op_valid = 1'b0; sif.op_a = ~a; sif.op_b = ~b; sif.op_ci = ~ci;
    for (int k = 1; k <= 5; k++) begin
      s   = (k > 4) ? 4 : k;
      ta  = a >> (12 * (s - 1));
      tb2 = b >> (12 * (s - 1));
      est = (k == 5) ? 5'b10000 : 5'(1 << (k - 1));
      checks++; if (strobes() !== est) begin errors++; $display("FAIL %s_strobes_c%0d: got %b expected %b", nm, k, strobes(), est); end
      checks++; if (sif.bus_a !== ta[11:0] || sif.bus_b !== tb2[11:0]) begin errors++; $display("FAIL %s_bus_c%0d: got %h/%h expected %h/%h", nm, k, sif.bus_a, sif.bus_b, ta[11:0], tb2[11:0]); end
      checks++; if (sif.ci48 !== ci) begin errors++; $display("FAIL %s_ci48_c%0d: got %b expected %b", nm, k, sif.ci48, ci); end
      checks++; if (sif.res_valid !== 1'b0 || sif.op_ready !== 1'b0) begin errors++; $display("FAIL %s_busy_c%0d: got valid=%b ready=%b expected 0/0", nm, k, sif.res_valid, sif.op_ready); end
      @(negedge clk);
    end
    checks++; if (sif.res_valid !== 1'b1) begin errors++; $display("FAIL %s_latency: got res_valid=%b expected 1 in cycle 6", nm, sif.res_valid); end
    checks++; if (sif.res_sum !== esum || sif.res_co !== eco) begin errors++; $display("FAIL %s_result: got %h/%b expected %h/%b", nm, sif.res_sum, sif.res_co, esum, eco); end
    checks++; if (strobes() !== 5'b0 || sif.ci48 !== 1'b0) begin errors++; $display("FAIL %s_done_idle_bus: got %b ci48=%b expected 00000/0", nm, strobes(), sif.ci48); end
`ifdef SA48_OVF_EN
    checks++; if (sif.res_ovf !== eovf) begin errors++; $display("FAIL %s_ovf: got %b expected %b", nm, sif.res_ovf, eovf); end
`else
    if (eovf === 1'bx) $display("note: eovf unknown");
`endif
    sif.res_ready = 1'b1;
    @(negedge clk);
    sif.res_ready = 1'b0;
    checks++; if (sif.res_valid !== 1'b0 || sif.op_ready !== 1'b0) begin errors++; $display("FAIL %s_gapw: got valid=%b ready=%b expected 0/0", nm, sif.res_valid, sif.op_ready); end
    checks++; if (sif.res_sum !== esum) begin errors++; $display("FAIL %s_hold: got %h expected %h", nm, sif.res_sum, esum); end
    @(negedge clk);
    checks++; if (sif.op_ready !== 1'b1) begin errors++; $display("FAIL %s_reissue: got op_ready=%b expected 1", nm, sif.op_ready); end
  endtask

  task automatic test_basic();
    do_op(48'h0000_0000_0FFF, 48'h0000_0000_0001, 1'b0, 48'h0000_0000_1000, 1'b0, 1'b0, "basic");
  endtask

  task automatic test_carry_out();
    do_op(48'h8000_0000_0000, 48'h8000_0000_0000, 1'b1, 48'h0000_0000_0001, 1'b1, 1'b1, "carry");
  endtask

  task automatic test_backpressure();
    sif.op_a = 48'h1234_5678_9ABC; sif.op_b = 48'h1111_1111_1111; sif.op_ci = 1'b0;
    sif.op_valid = 1'b1; sif.res_ready = 1'b0;
    @(negedge clk);
    sif.op_valid = 1'b0;
    repeat (5) @(negedge clk);
    sif.op_valid = 1'b1; sif.op_a = 48'hFFFF_FFFF_FFFF; sif.op_b = 48'hFFFF_FFFF_FFFF;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (sif.res_valid !== 1'b1 || sif.res_sum !== 48'h2345_6789_ABCD || sif.op_ready !== 1'b0 || sif.flag1 !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_c%0d: got valid=%b sum=%h ready=%b flag1=%b expected 1/234567 89abcd/0/0", i, sif.res_valid, sif.res_sum, sif.op_ready, sif.flag1);
      end
      @(negedge clk);
    end
    sif.op_valid = 1'b0; sif.res_ready = 1'b1;
    @(negedge clk);
    sif.res_ready = 1'b0;
    checks++; if (sif.res_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got %b expected 0", sif.res_valid); end
    @(negedge clk);
    checks++; if (sif.op_ready !== 1'b1 || sif.flag1 !== 1'b0) begin errors++; $display("FAIL bp_idle: got ready=%b flag1=%b expected 1/0", sif.op_ready, sif.flag1); end
  endtask

  task automatic test_reset_mid_op();
    int bad;
    sif.op_a = 48'h0000_0000_0FFF; sif.op_b = 48'h1; sif.op_ci = 1'b1;
    sif.op_valid = 1'b1; sif.res_ready = 1'b0;
    @(negedge clk);
    sif.op_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (sif.flag3 !== 1'b1) begin errors++; $display("FAIL rst_mid_sl3: got flag3=%b expected 1", sif.flag3); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (strobes() !== 5'b0 || sif.ci48 !== 1'b0 || sif.op_ready !== 1'b1 || sif.res_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_state: got strobes=%b ci48=%b ready=%b valid=%b expected 00000/0/1/0", strobes(), sif.ci48, sif.op_ready, sif.res_valid);
    end
    sif.res_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (sif.res_valid !== 1'b0 || strobes() !== 5'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL rst_mid_no_result: got %0d bad cycles expected 0", bad); end
    sif.res_ready = 1'b0;
  endtask

  task automatic test_res_ready_idle();
    sif.res_ready = 1'b1;
    repeat (3) @(negedge clk);
    sif.res_ready = 1'b0;
    checks++;
    if (sif.res_valid !== 1'b0 || sif.op_ready !== 1'b1 || sif.res_sum !== 48'd0) begin
      errors++;
      $display("FAIL idle_res_ready: got valid=%b ready=%b sum=%h expected 0/1/0", sif.res_valid, sif.op_ready, sif.res_sum);
    end
  endtask

  task automatic test_back_to_back();
    int acc[$];
    int overlap;
    int drained;
    overlap = 0;
    sif.op_a = 48'h0000_0000_0FFF; sif.op_b = 48'h1; sif.op_ci = 1'b0;
    sif.op_valid = 1'b1; sif.res_ready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if ($countones(strobes()) > 1) overlap++;
      if (sif.op_ready === 1'b1) acc.push_back(cyc);
      @(negedge clk);
    end
    sif.op_valid = 1'b0;
    checks++; if (overlap !== 0) begin errors++; $display("FAIL b2b_overlap: got %0d cycles expected 0", overlap); end
    checks++; if (acc.size() !== 5) begin errors++; $display("FAIL b2b_accepts: got %0d expected 5", acc.size()); end
    for (int i = 1; i < acc.size(); i++) begin
      checks++;
      if (acc[i] - acc[i-1] !== 8) begin errors++; $display("FAIL b2b_interval_%0d: got %0d expected 8", i, acc[i] - acc[i-1]); end
    end
    drained = 0;
    for (int i = 0; i < 30 && drained == 0; i++) begin
      if (sif.op_ready === 1'b1) drained = 1;
      else @(negedge clk);
    end
    sif.res_ready = 1'b0;
    checks++; if (drained !== 1) begin errors++; $display("FAIL b2b_drain: got op_ready=%b expected 1 within 30 cycles", sif.op_ready); end
    checks++; if (sif.res_sum !== 48'h1000) begin errors++; $display("FAIL b2b_sum: got %h expected 000000001000", sif.res_sum); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_carry_out();
    test_backpressure();
    test_reset_mid_op();
    test_res_ready_idle();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sa48_slice_sender.md
SA48_SLICE_SENDER -- requirements
Module: sa48_slice_sender

Interface
REQ-001 SHALL provide parameter GAP, default 1, meaning the number of idle cycles enforced after each result handshake (legal range 0..15).
REQ-002 SHALL provide: clk  in  1  the single clock, rising-edge active.
REQ-003 SHALL provide: rst  in  1  synchronous, active-high reset.
REQ-004 SHALL provide: op_valid  in  1  operand pair offered; op_ready  out  1  sender can accept.
REQ-005 SHALL provide: op_a  in  48, op_b  in  48, op_ci  in  1  operands and carry-in.
REQ-006 SHALL provide: bus_a  out  12, bus_b  out  12  current operand slice to the 48-bit datapath.
REQ-007 SHALL provide: flag1..flag4  out  1 each  one-hot slice strobes; load_ready  out  1  concatenate strobe; ci48  out  1  datapath carry-in.
REQ-008 SHALL provide: dp_result  in  48, dp_co  in  1  datapath sum and carry-out.
REQ-009 SHALL provide: res_valid  out  1, res_ready  in  1, res_sum  out  48, res_co  out  1  result handshake.

Function
REQ-010 SHALL implement states IDLE, SL1, SL2, SL3, SL4, LOAD, DONE, GAPW.
REQ-011 op_ready SHALL be 1 only in IDLE; an op is accepted on a clk edge with op_valid=1 and op_ready=1.
REQ-012 On accept SHALL latch op_a, op_b, op_ci and go IDLE->SL1.
REQ-013 SL1..SL4 SHALL each last exactly one cycle, advancing SL1->SL2->SL3->SL4->LOAD.
REQ-014 In SLn SHALL drive bus_a/bus_b = latched operand bits [12n-1:12n-12] and only flagn=1.
REQ-015 In LOAD SHALL drive load_ready=1, all flags 0, bus_a/bus_b held at slice 4.
REQ-016 ci48 SHALL equal latched op_ci in SL1..LOAD and 0 in all other states.
REQ-017 All datapath-side outputs SHALL be registered; flags and load_ready SHALL never be 1 together.
REQ-018 In IDLE, DONE and GAPW all flags and load_ready SHALL be 0, so the datapath clears its carries.
REQ-019 On the edge ending LOAD SHALL capture dp_result into res_sum and dp_co into res_co, and go to DONE.
REQ-020 In DONE res_valid SHALL be 1 and res_sum/res_co SHALL stay stable until res_ready=1.
REQ-021 On the DONE handshake edge SHALL go to GAPW with a counter of GAP, or to IDLE when GAP=0.
REQ-022 GAPW SHALL decrement each cycle and enter IDLE on the edge where the counter reaches 0.
REQ-023 Latency: res_valid SHALL first be 1 six cycles after the accept edge; minimum issue interval SHALL be 7+GAP cycles.
REQ-024 op_valid while busy SHALL be ignored; operand inputs SHALL be sampled only at accept.
REQ-025 res_ready while res_valid=0 SHALL have no effect.
REQ-026 res_sum and res_co SHALL hold their last captured value after the handshake, until the next LOAD capture.

Reset
REQ-027 rst=1 on a clk edge SHALL force IDLE from any state, including mid-slice or DONE, and discard any pending operation or result.
REQ-028 Reset values SHALL be: op_ready 1, res_valid 0, flag1..4 0, load_ready 0, ci48 0, bus_a/bus_b 0, res_sum 0, res_co 0, GAP counter 0.
REQ-029 op_ready SHALL be 1 on the first edge after rst deasserts; GAPW SHALL NOT be entered out of reset.

Configuration
REQ-030 With macro SA48_OVF_EN defined, SHALL add output res_ovf (out, 1): signed 48-bit overflow = (a[47]==b[47]) && (sum[47]!=a[47]), using the latched operands, captured with res_sum, reset 0.
REQ-031 Without SA48_OVF_EN, res_ovf SHALL NOT exist and behaviour SHALL be otherwise identical.

Verification
REQ-032 Basic: op_a=48'h0000_0000_0FFF, op_b=48'h1, op_ci=0, datapath model -> slices 12'hFFF/12'h001 then zero slices, res_sum=48'h1000, res_co=0, res_valid 6 cycles after accept.
REQ-033 Carry out: op_a=op_b=48'h8000_0000_0000, op_ci=1 -> res_sum=48'h1, res_co=1, ci48=1 in SL1..LOAD; with SA48_OVF_EN res_ovf=1.
REQ-034 Backpressure: res_ready held 0 for 10 cycles -> res_valid stays 1, res_sum stable, op_ready stays 0, a second op_valid is not accepted.
REQ-035 Back-to-back with GAP=1: res_ready=1 and op_valid=1 held high continuously -> accepts exactly 8 cycles apart, never two flags high together.
REQ-036 Reset mid-op: rst=1 during SL3 -> next cycle all flags 0, ci48 0, op_ready 1, res_valid 0, and no result is ever presented for that operation.
